// File: rtl/camera_fifo_burst_reader.sv
// Camera FIFO burst reader: requests one burst, streams BURST_LEN words out, steps the frame address.
// Optional underrun counter is compiled in with CAMERA_FIFO_BURST_READER_UNDERRUN_EN.
module camera_fifo_burst_reader #(
    parameter int unsigned              DATA_WIDTH   = 32,
    parameter int unsigned              BURST_LEN    = 256,
    parameter int unsigned              ADDR_WIDTH   = 28,
    parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR    = '0,
    parameter int unsigned              FRAME_BURSTS = 1800
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    input  logic                  fifo_almost_empty,
    output logic                  burst_req,
    output logic [ADDR_WIDTH-1:0] burst_addr,
    input  logic                  burst_ack,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  frame_done
`ifdef CAMERA_FIFO_BURST_READER_UNDERRUN_EN
    ,
    output logic [15:0]           underrun_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);
    localparam int unsigned FB_W  = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;

    localparam logic [CNT_W-1:0]      BURST_LEN_C = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]      LAST_IDX    = CNT_W'(BURST_LEN - 1);
    localparam logic [FB_W-1:0]       FRAME_LAST  = FB_W'(FRAME_BURSTS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP   = ADDR_WIDTH'(BURST_LEN * (DATA_WIDTH / 8));

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [FB_W-1:0]         bcnt_q, bcnt_d;
    logic [CNT_W-1:0]        issued_q, issued_d;
    logic                    frame_done_q, frame_done_d;
    logic                    inflight_q, inflight_d;
    logic                    inflight_last_q, inflight_last_d;

    logic [DATA_WIDTH-1:0]   buf_data_q [2];
    logic [1:0]              buf_last_q;
    logic                    wr_ptr_q;
    logic                    rd_ptr_q;
    logic [1:0]              buf_cnt_q;

    logic                    pop;
    logic                    head_last;
    logic [1:0]              occ;
    logic                    rd_en;

    assign m_valid    = (buf_cnt_q != 2'd0);
    assign m_data     = buf_data_q[rd_ptr_q];
    assign head_last  = buf_last_q[rd_ptr_q];
    assign m_last     = m_valid & head_last;
    assign pop        = m_valid & m_ready;
    assign burst_addr = addr_q;
    assign frame_done = frame_done_q;
    assign fifo_rd_en = rd_en;

    // Occupancy counts the word leaving this cycle as already gone, so reads keep pace with m_ready.
    assign occ = buf_cnt_q - {1'b0, pop} + {1'b0, inflight_q};

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        bcnt_d          = bcnt_q;
        issued_d        = issued_q;
        frame_done_d    = 1'b0;
        burst_req       = 1'b0;
        rd_en           = 1'b0;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_almost_empty) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                burst_req = 1'b1;
                issued_d  = '0;
                if (burst_ack) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                rd_en = !rst && (issued_q < BURST_LEN_C) && !fifo_empty && (occ < 2'd2);
                if (rd_en) begin
                    issued_d        = issued_q + CNT_W'(1);
                    inflight_d      = 1'b1;
                    inflight_last_d = (issued_q == LAST_IDX);
                end
                if (pop && head_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (bcnt_q == FRAME_LAST) begin
                    bcnt_d       = '0;
                    addr_d       = BASE_ADDR;
                    frame_done_d = 1'b1;
                end else begin
                    bcnt_d = bcnt_q + FB_W'(1);
                    addr_d = addr_q + ADDR_STEP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            addr_q          <= BASE_ADDR;
            bcnt_q          <= '0;
            issued_q        <= '0;
            frame_done_q    <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            bcnt_q          <= bcnt_d;
            issued_q        <= issued_d;
            frame_done_q    <= frame_done_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            buf_cnt_q  <= 2'd0;
            buf_last_q <= '0;
        end else begin
            if (inflight_q) begin
                buf_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            buf_cnt_q <= buf_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
        end
    end

    // Payload storage needs no reset; validity is carried by buf_cnt_q.
    always_ff @(posedge clk) begin
        if (inflight_q) begin
            buf_data_q[wr_ptr_q] <= fifo_rd_data;
        end
    end

`ifdef CAMERA_FIFO_BURST_READER_UNDERRUN_EN
    logic [15:0] underrun_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_q <= '0;
        end else if ((state_q == XFER) && fifo_empty && (issued_q < BURST_LEN_C)
                     && (underrun_q != '1)) begin
            underrun_q <= underrun_q + 16'd1;
        end
    end

    assign underrun_cnt = underrun_q;
`endif

endmodule

// File: tb/tb_camera_fifo_burst_reader.sv
// Self-checking bench for camera_fifo_burst_reader: FIFO/ack/sink models plus a stream scoreboard.
module tb_camera_fifo_burst_reader;

    localparam int unsigned DW   = 32;
    localparam int unsigned BL   = 256;
    localparam int unsigned AW   = 28;
    localparam int unsigned FB   = 3;
    localparam logic [AW-1:0] STEP = 28'h400;

    logic          clk;
    logic          rst;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_empty;
    logic          fifo_almost_empty;
    logic          burst_req;
    logic [AW-1:0] burst_addr;
    logic          burst_ack;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready;
    logic          frame_done;
`ifdef CAMERA_FIFO_BURST_READER_UNDERRUN_EN
    logic [15:0]   underrun_cnt;
`endif

    camera_fifo_burst_reader #(
        .DATA_WIDTH   (DW),
        .BURST_LEN    (BL),
        .ADDR_WIDTH   (AW),
        .BASE_ADDR    (28'h0),
        .FRAME_BURSTS (FB)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .fifo_rd_en        (fifo_rd_en),
        .fifo_rd_data      (fifo_rd_data),
        .fifo_empty        (fifo_empty),
        .fifo_almost_empty (fifo_almost_empty),
        .burst_req         (burst_req),
        .burst_addr        (burst_addr),
        .burst_ack         (burst_ack),
        .m_valid           (m_valid),
        .m_data            (m_data),
        .m_last            (m_last),
        .m_ready           (m_ready),
        .frame_done        (frame_done)
`ifdef CAMERA_FIFO_BURST_READER_UNDERRUN_EN
        ,
        .underrun_cnt      (underrun_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model state: FIFO contents, words owed to the stream, burst bookkeeping.
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] pend_word;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] req_addr;
    bit            pend_rd, prev_stall, prev_last, ack_next, req_prev, in_burst;
    bit            ready_tgl, chk_rst_vals;
    int            ready_mode, stall_at;
    int unsigned   ready_pct, stall_len, force_empty;
    int unsigned   xfer_cnt, popped, burst_idx, bursts_total, fd_cd, fd_seen, rd_pulses;
    int unsigned   cyc, entry_cyc, first_cyc, last_cyc, uexp, word_ctr;

    typedef struct {
        int            ready_mode;
        int            stall_at;
        int unsigned   stall_len;
        logic [AW-1:0] exp_addr;
        int unsigned   exp_rd;
        int unsigned   exp_fd;
        int            exp_span;
        int unsigned   exp_uflow;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_words(input int unsigned n, input bit rnd);
        for (int unsigned i = 0; i < n; i++) begin
            fifo_q.push_back(rnd ? DW'($urandom) : DW'(word_ctr));
            word_ctr++;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        pend_rd     = 1'b0;
        force_empty = 0;
        in_burst    = 1'b0;
        xfer_cnt    = 0;
        popped      = 0;
        burst_idx   = 0;
        fd_cd       = 0;
        prev_stall  = 1'b0;
        ack_next    = 1'b0;
        req_prev    = 1'b0;
        uexp        = 0;
    endtask

    task automatic cycle();
        logic [DW-1:0] w;
        @(negedge clk);
        if (pend_rd) fifo_rd_data = pend_word;
        pend_rd           = 1'b0;
        fifo_empty        = (fifo_q.size() == 0) || (force_empty != 0);
        fifo_almost_empty = (fifo_q.size() < BL);
        burst_ack         = ack_next;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       begin ready_tgl = ~ready_tgl; m_ready = ready_tgl; end
            default: m_ready = ($urandom_range(0, 99) < ready_pct);
        endcase
        #1;
        cyc++;
        if (rst) begin
            model_reset();
        end else begin
            if (chk_rst_vals) begin
                chk("rst_rd_en", fifo_rd_en, 0);
                chk("rst_burst_req", burst_req, 0);
                chk("rst_m_valid", m_valid, 0);
                chk("rst_m_last", m_last, 0);
                chk("rst_frame_done", frame_done, 0);
                chk("rst_burst_addr", burst_addr, 0);
`ifdef CAMERA_FIFO_BURST_READER_UNDERRUN_EN
                chk("rst_underrun", underrun_cnt, 0);
`endif
                chk_rst_vals = 1'b0;
            end
            chk("frame_done", frame_done, fd_cd == 1);
            if (frame_done) fd_seen++;
            if (fd_cd != 0) fd_cd--;
            if (burst_req && !req_prev) begin
                chk("req_overlap", in_burst, 0);
                chk("burst_addr", burst_addr, AW'(burst_idx) * STEP);
                req_addr = burst_addr;
            end
            if (in_burst && fifo_empty && popped < BL && uexp != 16'hFFFF) uexp++;
            if (prev_stall) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, prev_data);
                chk("hold_last", m_last, prev_last);
            end
            if (force_empty != 0) force_empty--;
            if (fifo_rd_en) begin
                chk("rd_when_empty", fifo_empty, 0);
                chk("rd_past_burst", popped >= BL, 0);
                if (fifo_q.size() != 0) begin
                    pend_word = fifo_q.pop_front();
                    exp_q.push_back(pend_word);
                    pend_rd = 1'b1;
                end
                popped++;
                rd_pulses++;
                if (stall_at >= 0 && popped == unsigned'(stall_at + 1)) force_empty = stall_len;
            end
            if (m_valid && m_ready) begin
                if (xfer_cnt == 0) first_cyc = cyc;
                last_cyc = cyc;
                w = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                chk("m_data", m_data, w);
                chk("m_last", m_last, xfer_cnt == BL - 1);
                xfer_cnt++;
                if (xfer_cnt == BL) begin
                    in_burst = 1'b0;
                    bursts_total++;
                    burst_idx++;
                    if (burst_idx == FB) begin
                        burst_idx = 0;
                        fd_cd     = 2;
                    end
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            ack_next   = burst_req && !burst_ack;
            if (burst_req && burst_ack) begin
                in_burst  = 1'b1;
                xfer_cnt  = 0;
                popped    = 0;
                entry_cyc = cyc + 1;
            end
            req_prev = burst_req;
        end
    endtask

    task automatic run_until(input int unsigned target, input int unsigned budget, input string name);
        int unsigned n;
        n = 0;
        while (bursts_total < target && n < budget) begin
            cycle();
            n++;
        end
        chk(name, bursts_total >= target, 1);
    endtask

    initial begin
        int unsigned u0, n, extra;
        rst = 1'b1; m_ready = 1'b0; fifo_empty = 1'b1; fifo_almost_empty = 1'b1;
        burst_ack = 1'b0; fifo_rd_data = '0;
        ready_mode = 0; ready_pct = 100; stall_at = -1; stall_len = 0; ready_tgl = 1'b0;
        chk_rst_vals = 1'b0; bursts_total = 0; word_ctr = 0; cyc = 0;
        model_reset();
        repeat (3) cycle();
        rst = 1'b0;
        chk_rst_vals = 1'b1;
        cycle();

        vecs[0] = '{0, -1,  0, 28'h000, 256, 0, 255,  0};
        vecs[1] = '{1, -1,  0, 28'h400, 256, 0,  -1,  0};
        vecs[2] = '{0, 100, 10, 28'h800, 256, 1, 265, 10};
        vecs[3] = '{2, -1,  0, 28'h000, 256, 0,  -1,  0};

        for (int i = 0; i < 4; i++) begin
            push_words(BL - fifo_q.size(), 1'b0);
            ready_mode = vecs[i].ready_mode;
            ready_pct  = 50;
            stall_at   = vecs[i].stall_at;
            stall_len  = vecs[i].stall_len;
            rd_pulses  = 0;
            fd_seen    = 0;
            u0         = uexp;
            run_until(bursts_total + 1, 3000, "vec_timeout");
            repeat (4) cycle();
            chk("vec_addr", req_addr, vecs[i].exp_addr);
            chk("vec_rd_pulses", rd_pulses, vecs[i].exp_rd);
            chk("vec_frame_done", fd_seen, vecs[i].exp_fd);
            if (vecs[i].exp_span >= 0) begin
                chk("vec_latency", first_cyc - entry_cyc, 2);
                chk("vec_span", last_cyc - first_cyc, vecs[i].exp_span);
            end
`ifdef CAMERA_FIFO_BURST_READER_UNDERRUN_EN
            chk("vec_underrun", underrun_cnt, u0 + vecs[i].exp_uflow);
`endif
        end

        for (int r = 0; r < 6; r++) begin
            extra = $urandom_range(0, 40);
            push_words(BL + extra - fifo_q.size(), 1'b1);
            ready_mode = 2;
            ready_pct  = $urandom_range(30, 100);
            stall_at   = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 254)) : -1;
            stall_len  = $urandom_range(1, 12);
            rd_pulses  = 0;
            run_until(bursts_total + 1, 4000, "rand_timeout");
            repeat (3) cycle();
            chk("rand_rd_pulses", rd_pulses, BL);
        end
`ifdef CAMERA_FIFO_BURST_READER_UNDERRUN_EN
        chk("underrun_total", underrun_cnt, uexp);
`endif

        // Reset in the middle of a burst, then the next burst must start from the base address.
        push_words(BL + 8 - fifo_q.size(), 1'b1);
        ready_mode = 0;
        stall_at   = -1;
        n = 0;
        while (!(in_burst && xfer_cnt >= 50) && n < 2000) begin
            cycle();
            n++;
        end
        chk("reach_word50", in_burst && xfer_cnt >= 50, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk_rst_vals = 1'b1;
        cycle();
        push_words(BL - fifo_q.size(), 1'b1);
        run_until(bursts_total + 1, 3000, "post_rst_timeout");
        repeat (3) cycle();
        chk("post_rst_addr", req_addr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

endmodule
